// File: rtl/flexbex_ibex_multdiv_issue_pkg.sv
// Shared definitions for the mult/div issue slice.
//   req_op_e      : 3-bit M-extension op as decoded by the EX stage
//   md_op_e       : 2-bit operator understood by flexbex_ibex_multdiv_fast
//   issue_state_e : issue FSM states
//   md_ctrl_t     : {operator, signed_mode} pair driven to the unit
//   md_ctrl_decode: req_op -> md_ctrl_t table
//   md_is_div     : true for operators that run on the divider
package flexbex_ibex_multdiv_issue_pkg;

   localparam int unsigned DataWidth     = 32;
   localparam int unsigned AdderOpWidth  = 33;
   localparam int unsigned AdderExtWidth = 34;
   localparam int unsigned RegAddrWidth  = 5;

   typedef enum logic [2:0] {
      ReqMul    = 3'd0,
      ReqMulh   = 3'd1,
      ReqMulhsu = 3'd2,
      ReqMulhu  = 3'd3,
      ReqDiv    = 3'd4,
      ReqDivu   = 3'd5,
      ReqRem    = 3'd6,
      ReqRemu   = 3'd7
   } req_op_e;

   typedef enum logic [1:0] {
      MdOpMull = 2'd0,
      MdOpMulh = 2'd1,
      MdOpDiv  = 2'd2,
      MdOpRem  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StResp  = 2'd2,
      StDrain = 2'd3
   } issue_state_e;

   // signed_mode[0]: op_a signed, signed_mode[1]: op_b signed
   typedef struct packed {
      md_op_e     md_op;
      logic [1:0] signed_mode;
   } md_ctrl_t;

   function automatic md_ctrl_t md_ctrl_decode(input req_op_e op);
      md_ctrl_t ctrl;
      ctrl.md_op       = MdOpMull;
      ctrl.signed_mode = 2'b00;
      unique case (op)
         ReqMul:    begin ctrl.md_op = MdOpMull; ctrl.signed_mode = 2'b00; end
         ReqMulh:   begin ctrl.md_op = MdOpMulh; ctrl.signed_mode = 2'b11; end
         ReqMulhsu: begin ctrl.md_op = MdOpMulh; ctrl.signed_mode = 2'b01; end
         ReqMulhu:  begin ctrl.md_op = MdOpMulh; ctrl.signed_mode = 2'b00; end
         ReqDiv:    begin ctrl.md_op = MdOpDiv;  ctrl.signed_mode = 2'b11; end
         ReqDivu:   begin ctrl.md_op = MdOpDiv;  ctrl.signed_mode = 2'b00; end
         ReqRem:    begin ctrl.md_op = MdOpRem;  ctrl.signed_mode = 2'b11; end
         ReqRemu:   begin ctrl.md_op = MdOpRem;  ctrl.signed_mode = 2'b00; end
      endcase
      return ctrl;
   endfunction

   function automatic logic md_is_div(input md_op_e op);
      return (op == MdOpDiv) || (op == MdOpRem);
   endfunction

endpackage

// File: rtl/flexbex_ibex_multdiv_adder.sv
// 34-bit extended adder shared with the mult/div unit (and usable by the ALU).
//   operand_a, operand_b : 33-bit adder operands
//   adder_ext            : {1'b0,operand_a} + {1'b0,operand_b}
//   adder                : adder_ext[32:1], the 32-bit result with the
//                          carry-in bit position stripped off
module flexbex_ibex_multdiv_adder
   import flexbex_ibex_multdiv_issue_pkg::*;
(
   input  logic [AdderOpWidth-1:0]  operand_a,
   input  logic [AdderOpWidth-1:0]  operand_b,
   output logic [AdderExtWidth-1:0] adder_ext,
   output logic [DataWidth-1:0]     adder
);

   // Zero-extending to 34 bits means the sum can never overflow.
   assign adder_ext = {1'b0, operand_a} + {1'b0, operand_b};
   assign adder     = adder_ext[DataWidth:1];

endmodule

// File: rtl/flexbex_ibex_multdiv_issue.sv
// Initiator side of the fast mult/div unit interface.
// Takes one decoded M op from EX, holds its operands for the whole operation,
// drives the unit's enables/operator/signed_mode, provides the shared adder,
// captures the result on md_ready_i and offers it to writeback on a
// valid/ready handshake. Pipeline flushes either drain the unit (RUN) or drop
// the pending response (RESP).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid_i/req_ready_o         EX request handshake
//   req_op_i, req_a_i, req_b_i,
//   req_rd_i                        op code, rs1/rs2 values, destination reg
//   flush_i                         kill in-flight op
//   md_mult_en_o, md_div_en_o       unit enables
//   md_operator_o, md_signed_mode_o unit operator and operand signedness
//   md_op_a_o, md_op_b_o            registered operands
//   md_alu_operand_a_i/_b_i         adder operands requested by the unit
//   md_alu_adder_ext_o, md_alu_adder_o  adder results
//   md_equal_to_zero_o              md_op_b_o == 0
//   md_result_i, md_ready_i         unit result and done strobe
//   wb_valid_o/wb_ready_i           writeback handshake
//   wb_rd_o, wb_data_o              writeback destination and data
//   busy_o                          FSM not idle
module flexbex_ibex_multdiv_issue
   import flexbex_ibex_multdiv_issue_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,

   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [2:0]               req_op_i,
   input  logic [DataWidth-1:0]     req_a_i,
   input  logic [DataWidth-1:0]     req_b_i,
   input  logic [RegAddrWidth-1:0]  req_rd_i,
   input  logic                     flush_i,

   output logic                     md_mult_en_o,
   output logic                     md_div_en_o,
   output logic [1:0]               md_operator_o,
   output logic [1:0]               md_signed_mode_o,
   output logic [DataWidth-1:0]     md_op_a_o,
   output logic [DataWidth-1:0]     md_op_b_o,
   input  logic [AdderOpWidth-1:0]  md_alu_operand_a_i,
   input  logic [AdderOpWidth-1:0]  md_alu_operand_b_i,
   output logic [AdderExtWidth-1:0] md_alu_adder_ext_o,
   output logic [DataWidth-1:0]     md_alu_adder_o,
   output logic                     md_equal_to_zero_o,
   input  logic [DataWidth-1:0]     md_result_i,
   input  logic                     md_ready_i,

   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [RegAddrWidth-1:0]  wb_rd_o,
   output logic [DataWidth-1:0]     wb_data_o,
   output logic                     busy_o
);

   issue_state_e              state_q;
   md_ctrl_t                  ctrl_q;
   logic [DataWidth-1:0]      op_a_q;
   logic [DataWidth-1:0]      op_b_q;
   logic [RegAddrWidth-1:0]   rd_q;
   logic [DataWidth-1:0]      wb_data_q;
   logic                      wb_valid_q;
   logic                      mult_en_q;
   logic                      div_en_q;

   md_ctrl_t                  req_ctrl;
   logic                      req_is_div;
   logic                      accept;

   // A new op may enter while idle, or in the same cycle the pending response
   // is consumed; a flush always blocks entry.
   always_comb begin
      req_ready_o = !flush_i && ((state_q == StIdle) || ((state_q == StResp) && wb_ready_i));
      accept      = req_valid_i && req_ready_o;
      req_ctrl    = md_ctrl_decode(req_op_e'(req_op_i));
      req_is_div  = md_is_div(req_ctrl.md_op);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ctrl_q     <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         mult_en_q  <= 1'b0;
         div_en_q   <= 1'b0;
      end else if (accept) begin
         // Only reachable from IDLE or a consumed RESP.
         state_q    <= StRun;
         ctrl_q     <= req_ctrl;
         op_a_q     <= req_a_i;
         op_b_q     <= req_b_i;
         rd_q       <= req_rd_i;
         wb_valid_q <= 1'b0;
         mult_en_q  <= !req_is_div;
         div_en_q   <= req_is_div;
      end else begin
         unique case (state_q)
            StIdle: ;
            StRun: begin
               // The unit only advances while enabled, so the enable stays up
               // through the md_ready_i cycle even when flushed.
               if (md_ready_i) begin
                  mult_en_q <= 1'b0;
                  div_en_q  <= 1'b0;
                  if (flush_i) begin
                     state_q <= StIdle;
                  end else begin
                     state_q    <= StResp;
                     wb_data_q  <= md_result_i;
                     wb_valid_q <= 1'b1;
                  end
               end else if (flush_i) begin
                  state_q <= StDrain;
               end
            end
            StResp: begin
               if (flush_i || wb_ready_i) begin
                  state_q    <= StIdle;
                  wb_valid_q <= 1'b0;
               end
            end
            StDrain: begin
               // Result of a flushed op is discarded.
               if (md_ready_i) begin
                  state_q   <= StIdle;
                  mult_en_q <= 1'b0;
                  div_en_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   flexbex_ibex_multdiv_adder u_adder (
      .operand_a (md_alu_operand_a_i),
      .operand_b (md_alu_operand_b_i),
      .adder_ext (md_alu_adder_ext_o),
      .adder     (md_alu_adder_o)
   );

   assign md_mult_en_o       = mult_en_q;
   assign md_div_en_o        = div_en_q;
   assign md_operator_o      = ctrl_q.md_op;
   assign md_signed_mode_o   = ctrl_q.signed_mode;
   assign md_op_a_o          = op_a_q;
   assign md_op_b_o          = op_b_q;
   assign md_equal_to_zero_o = (op_b_q == '0);
   assign wb_valid_o         = wb_valid_q;
   assign wb_rd_o            = rd_q;
   assign wb_data_o          = wb_data_q;
   assign busy_o             = (state_q != StIdle);

endmodule
